// File: rtl/div_unit.sv
// Multi-cycle integer divider: restoring radix-2, one quotient bit per cycle.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   div_valid, signed_div start request, 1 = signed (DIV) / 0 = unsigned (DIVU)
//   opa, opb              dividend, divisor
//   annul                 flush, cancels any operation in progress
//   div_stall             stall request while a division is pending
//   ready                 one-cycle pulse, result valid
//   result                {remainder (HI), quotient (LO)}
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               div_valid,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    input  logic               annul,
    output logic               div_stall,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);

    typedef enum logic [1:0] {IDLE, ZERO, RUN, DONE} state_t;

    state_t state, state_n;

    logic [5:0]       cnt;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sgn_q;
    logic [WIDTH-1:0] rem, quo;

    logic [WIDTH-1:0] a_in_mag, b_mag;
    logic [WIDTH:0]   sh;
    logic [WIDTH+1:0] diff;
    logic             fits;
    logic [WIDTH-1:0] rem_n, quo_n;
    logic             neg_q, neg_r;
    logic [WIDTH-1:0] q_fix, r_fix;

    // Dividend magnitude is loaded straight into the quotient register
    // at start; divisor magnitude is derived from the latched copy.
    always_comb begin
        a_in_mag = (signed_div && opa[WIDTH-1]) ? -opa : opa;
        b_mag    = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;

        // {rem,quo} << 1: upper half gains quo's MSB, kept WIDTH+1 wide
        // because an unsigned partial remainder can exceed WIDTH bits.
        sh    = {rem, quo[WIDTH-1]};
        diff  = {1'b0, sh} - {2'b00, b_mag};
        fits  = ~diff[WIDTH+1];
        rem_n = fits ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
        quo_n = {quo[WIDTH-2:0], fits};

        // Quotient negative on sign mismatch; remainder follows dividend.
        neg_q = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_r = sgn_q & a_q[WIDTH-1];
        q_fix = neg_q ? -quo_n : quo_n;
        r_fix = neg_r ? -rem_n : rem_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (div_valid && !annul) begin
                    state_n = (opb == '0) ? ZERO : RUN;
                end
            end
            ZERO: state_n = DONE;
            RUN: begin
                if (cnt == 6'(WIDTH - 1)) begin
                    state_n = DONE;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (annul) begin
            state_n = IDLE;
        end
    end

    always_comb begin
        ready     = (state == DONE) && !annul;
        div_stall = ((state == IDLE) && div_valid && !annul)
                  || (state == ZERO)
                  || (state == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= 1'b0;
            rem    <= '0;
            quo    <= '0;
            result <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (state_n != IDLE) begin
                        a_q   <= opa;
                        b_q   <= opb;
                        sgn_q <= signed_div;
                        rem   <= '0;
                        quo   <= a_in_mag;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    rem <= rem_n;
                    quo <= quo_n;
                    cnt <= cnt + 6'd1;
                    if (state_n == DONE) begin
                        result <= {r_fix, q_fix};
                    end
                end
                ZERO: begin
                    if (state_n == DONE) begin
                        result <= {a_q, {WIDTH{1'b1}}};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed vectors, expected results queued
// at issue time and checked by an independent monitor on each ready pulse.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_valid;
    logic        signed_div;
    logic [31:0] opa, opb;
    logic        annul;
    logic        div_stall;
    logic        ready;
    logic [63:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_q[$];
    string       name_q[$];

    div_unit #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .div_valid(div_valid),
        .signed_div(signed_div),
        .opa(opa),
        .opb(opb),
        .annul(annul),
        .div_stall(div_stall),
        .ready(ready),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ready: got result %h expected none",
                         result);
            end else begin
                chk(name_q.pop_front(), result, exp_q.pop_front());
            end
        end
    end

    // Issue one op, check stall/ready timing cycle by cycle.
    task automatic run_op(input string nm, input logic [31:0] a,
                          input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input int lat,
                          input bit hold);
        @(negedge clk);
        div_valid  = 1'b1;
        signed_div = s;
        opa        = a;
        opb        = b;
        #1 chk({nm, "_stall_start"}, 64'(div_stall), 64'd1);
        @(posedge clk);
        #1;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        if (hold) begin
            opa = 32'h1234_5678;
            opb = 32'h0000_0003;
            signed_div = ~s;
        end else begin
            div_valid = 1'b0;
        end
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            chk({nm, "_ready_t"}, 64'(ready), 64'(k == lat));
            chk({nm, "_stall_t"}, 64'(div_stall), 64'(k < lat));
            if (k == lat) div_valid = 1'b0;
        end
        @(negedge clk);
        chk({nm, "_hold_result"}, result, exp);
        chk({nm, "_ready_after"}, 64'(ready), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        div_valid  = 1'b0;
        signed_div = 1'b0;
        opa        = '0;
        opb        = '0;
        annul      = 1'b0;
        #2;
        chk("rst_result", result, 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_stall", 64'(div_stall), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("udiv_100_7", 32'd100, 32'd7, 1'b0,
               {32'h0000_0002, 32'h0000_000E}, 33, 1'b0);
        run_op("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1,
               {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1'b1);
        run_op("udiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0,
               {32'h0000_0001, 32'h7FFF_FFFC}, 33, 1'b0);
        run_op("div0_5", 32'd5, 32'd0, 1'b0,
               {32'h0000_0005, 32'hFFFF_FFFF}, 2, 1'b0);
        run_op("sdiv_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
               {32'h0000_0000, 32'h8000_0000}, 33, 1'b0);
        run_op("udiv_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
               {32'h8000_0000, 32'h0000_0000}, 33, 1'b0);
        run_op("sdiv_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1,
               {32'hFFFF_FFFE, 32'h0000_000E}, 33, 1'b0);

        // valid together with annul in IDLE must not start
        @(negedge clk);
        div_valid = 1'b1;
        annul     = 1'b1;
        opa       = 32'd50;
        opb       = 32'd5;
        #1 chk("va_stall", 64'(div_stall), 64'd0);
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        annul     = 1'b0;
        @(negedge clk);
        chk("va_no_start", 64'(div_stall), 64'd0);

        // annul in cycle T+10 of a running division
        @(negedge clk);
        div_valid  = 1'b1;
        signed_div = 1'b0;
        opa        = 32'd100;
        opb        = 32'd7;
        @(posedge clk);
        #1 div_valid = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        annul = 1'b1;
        @(posedge clk);
        #1 annul = 1'b0;
        @(negedge clk);
        chk("annul_stall", 64'(div_stall), 64'd0);
        chk("annul_ready", 64'(ready), 64'd0);
        run_op("udiv_9_3", 32'd9, 32'd3, 1'b0,
               {32'h0000_0000, 32'h0000_0003}, 33, 1'b0);

        // reset pulse between edges mid-RUN
        @(negedge clk);
        div_valid = 1'b1;
        opa       = 32'd100;
        opb       = 32'd7;
        @(posedge clk);
        #1 div_valid = 1'b0;
        for (int k = 1; k <= 20; k++) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_result", result, 64'd0);
        chk("midrst_ready", 64'(ready), 64'd0);
        chk("midrst_stall", 64'(div_stall), 64'd0);
        #1 rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
        end
        chk("midrst_idle_stall", 64'(div_stall), 64'd0);
        run_op("post_rst_1000_33", 32'd1000, 32'd33, 1'b0,
               {32'h0000_000A, 32'h0000_001E}, 33, 1'b0);

        repeat (40) @(negedge clk);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand width; all values in this document use WIDTH=32.
REQ-002 The port clk SHALL be an input of width 1: the single clock; all state updates on its rising edge.
REQ-003 The port rst SHALL be an input of width 1: reset, asynchronous, active-high.
REQ-004 The port div_valid SHALL be an input of width 1: start request from the decode stage (already gated by stallD).
REQ-005 The port signed_div SHALL be an input of width 1: 1 = signed (DIV), 0 = unsigned (DIVU); sampled with div_valid.
REQ-006 The port opa SHALL be an input of width WIDTH: dividend (rs).
REQ-007 The port opb SHALL be an input of width WIDTH: divisor (rt).
REQ-008 The port annul SHALL be an input of width 1: flush; cancels any operation in progress.
REQ-009 The port div_stall SHALL be an output of width 1: pipeline stall request while a division is pending.
REQ-010 The port ready SHALL be an output of width 1: one-cycle pulse, result valid.
REQ-011 The port result SHALL be an output of width 2*WIDTH: {remainder→HI, quotient→LO}.

Function
REQ-012 The FSM SHALL have four states, IDLE, ZERO, RUN and DONE, and SHALL reset to IDLE.
REQ-013 In IDLE with div_valid=1 and annul=0, the block SHALL latch opa, opb and signed_div at the clock edge; next state ZERO if opb==0, else RUN.
REQ-014 div_valid SHALL be ignored in ZERO, RUN and DONE; operands are used only from the latched copies.
REQ-015 Signed mode SHALL convert the latched operands to magnitudes (two's complement of any negative operand) before iterating.
REQ-016 RUN SHALL perform one restoring radix-2 step per cycle: shift {rem,quo} left by 1, trial-subtract the divisor magnitude from the upper half, and on non-negative keep the difference and set quotient bit 0.
REQ-017 A 6-bit counter SHALL clear on RUN entry and advance once per RUN cycle; after exactly WIDTH (32) RUN cycles the next state SHALL be DONE.
REQ-018 ZERO SHALL last exactly one cycle and then go to DONE with quotient = all ones and remainder = latched dividend unmodified.
REQ-019 On DONE entry in signed mode, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL wrap: quotient 0x80000000, remainder 0.
REQ-021 In DONE, ready SHALL be 1 and result valid for exactly that one cycle; next state SHALL be IDLE unconditionally.
REQ-022 Latency SHALL be: start sampled at edge T, ready high in cycle T+33 for a normal division; ready high in cycle T+2 for divide-by-zero.
REQ-023 div_stall SHALL be combinational: 1 when (IDLE and div_valid and not annul), in ZERO, or in RUN; 0 in DONE and otherwise.
REQ-024 result SHALL hold its last DONE value outside DONE; it SHALL be 0 after reset.
REQ-025 annul=1 in any state SHALL force next state IDLE with no ready pulse; annul in DONE SHALL suppress ready in that cycle.
REQ-026 div_valid and annul asserted together in IDLE SHALL not start an operation.

Reset
REQ-027 When rst=1, at any time including mid-RUN, the block SHALL immediately drive state IDLE, counter 0, latched operands 0, result 0, ready 0 and div_stall 0 (given div_valid=0).
REQ-028 The first start after reset deassertion SHALL be accepted normally.

Verification
REQ-029 The bench SHALL cover an unsigned division: 100 / 7, start at T -> div_stall high T..T+32, ready in T+33 only, result = {0x00000002, 0x0000000E}.
REQ-030 The bench SHALL cover a signed division: 0xFFFFFFF9 (-7) / 2 -> result = {0xFFFFFFFF, 0xFFFFFFFD}; the same operands unsigned -> {0x00000001, 0x7FFFFFFC}.
REQ-031 The bench SHALL cover divide-by-zero: 5 / 0 -> ready in T+2, result = {0x00000005, 0xFFFFFFFF}.
REQ-032 The bench SHALL cover the overflow case: 0x80000000 / 0xFFFFFFFF signed -> {0, 0x80000000}; unsigned -> {0x80000000, 0}.
REQ-033 The bench SHALL cover annul: annul in T+10 -> IDLE at T+11, no ready, div_stall low; a new 9 / 3 started next yields {0, 3} 33 cycles later.
REQ-034 The bench SHALL cover reset mid-operation: rst pulsed at T+20 (between edges) -> outputs 0 immediately, no ready, and a subsequent start completes correctly.
